// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory read port between the fetch (IF) and the
// load/store (LS) requesters.
//
// Handshake: a requester raises *_rd_enable with a stable address and holds
// it until its *_rd_ready pulses for one cycle, qualifying *_rd_data. Toward
// memory, mem_rd_enable is a level held from grant until mem_rd_ready is
// sampled high; mem_rd_ready qualifies mem_rd_data on that same edge.
//
// Configuration macro ARB_ROUND_ROBIN_EN: when defined, simultaneous
// requests alternate via a last-grant register (reset to IF, so LS takes
// the first tie). When undefined, LS always wins a tie.
//
// While a ready pulse is on the outputs, no new grant is made. A requester
// that only drops its enable once it has seen ready is therefore never
// served twice for one request.

`ifndef ADDR_SIZE
`define ADDR_SIZE 31
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 31
`endif

module mem_arbiter (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_rd_enable,
    input  logic [`ADDR_SIZE:0]  if_rd_addr,
    output logic                 if_rd_ready,
    output logic [`INSTR_SIZE:0] if_rd_data,
    input  logic                 ls_rd_enable,
    input  logic [`ADDR_SIZE:0]  ls_rd_addr,
    output logic                 ls_rd_ready,
    output logic [`INSTR_SIZE:0] ls_rd_data,
    input  logic                 flush,
    output logic                 mem_rd_enable,
    output logic [`ADDR_SIZE:0]  mem_rd_addr,
    input  logic                 mem_rd_ready,
    input  logic [`INSTR_SIZE:0] mem_rd_data,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IF = 2'd1,
        GRANT_LS = 2'd2,
        DRAIN    = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic                 mem_rd_enable_q, mem_rd_enable_d;
    logic [`ADDR_SIZE:0]  mem_rd_addr_q, mem_rd_addr_d;
    logic                 if_rd_ready_q, if_rd_ready_d;
    logic                 ls_rd_ready_q, ls_rd_ready_d;
    logic [`INSTR_SIZE:0] if_rd_data_q, if_rd_data_d;
    logic [`INSTR_SIZE:0] ls_rd_data_q, ls_rd_data_d;
    logic                 if_req, ls_req, pick_ls;
`ifdef ARB_ROUND_ROBIN_EN
    // 0 = IF was granted last, 1 = LS was granted last
    logic                 last_ls_q, last_ls_d;
`endif

    // Next-state and output computation for the arbitration FSM
    always_comb begin
        state_d         = state_q;
        mem_rd_enable_d = mem_rd_enable_q;
        mem_rd_addr_d   = mem_rd_addr_q;
        if_rd_ready_d   = 1'b0;
        ls_rd_ready_d   = 1'b0;
        if_rd_data_d    = if_rd_data_q;
        ls_rd_data_d    = ls_rd_data_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_ls_d       = last_ls_q;
`endif
        // No grant while a ready pulse is still being presented
        if_req  = if_rd_enable && !flush && !if_rd_ready_q && !ls_rd_ready_q;
        ls_req  = ls_rd_enable && !if_rd_ready_q && !ls_rd_ready_q;
`ifdef ARB_ROUND_ROBIN_EN
        pick_ls = ls_req && (!if_req || !last_ls_q);
`else
        pick_ls = ls_req;
`endif

        case (state_q)
            IDLE: begin
                if (pick_ls) begin
                    state_d         = GRANT_LS;
                    mem_rd_enable_d = 1'b1;
                    mem_rd_addr_d   = ls_rd_addr;
`ifdef ARB_ROUND_ROBIN_EN
                    last_ls_d       = 1'b1;
`endif
                end else if (if_req) begin
                    state_d         = GRANT_IF;
                    mem_rd_enable_d = 1'b1;
                    mem_rd_addr_d   = if_rd_addr;
`ifdef ARB_ROUND_ROBIN_EN
                    last_ls_d       = 1'b0;
`endif
                end
            end
            GRANT_IF: begin
                if (flush) begin
                    // Fetch abandoned: memory must still complete the read
                    if (mem_rd_ready) begin
                        state_d         = IDLE;
                        mem_rd_enable_d = 1'b0;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (mem_rd_ready) begin
                    state_d         = IDLE;
                    mem_rd_enable_d = 1'b0;
                    if_rd_ready_d   = 1'b1;
                    if_rd_data_d    = mem_rd_data;
                end
            end
            GRANT_LS: begin
                if (mem_rd_ready) begin
                    state_d         = IDLE;
                    mem_rd_enable_d = 1'b0;
                    ls_rd_ready_d   = 1'b1;
                    ls_rd_data_d    = mem_rd_data;
                end
            end
            DRAIN: begin
                if (mem_rd_ready) begin
                    state_d         = IDLE;
                    mem_rd_enable_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            mem_rd_enable_q <= 1'b0;
            mem_rd_addr_q   <= '0;
            if_rd_ready_q   <= 1'b0;
            ls_rd_ready_q   <= 1'b0;
            if_rd_data_q    <= '0;
            ls_rd_data_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_ls_q       <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            mem_rd_enable_q <= mem_rd_enable_d;
            mem_rd_addr_q   <= mem_rd_addr_d;
            if_rd_ready_q   <= if_rd_ready_d;
            ls_rd_ready_q   <= ls_rd_ready_d;
            if_rd_data_q    <= if_rd_data_d;
            ls_rd_data_q    <= ls_rd_data_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_ls_q       <= last_ls_d;
`endif
        end
    end

    assign mem_rd_enable = mem_rd_enable_q;
    assign mem_rd_addr   = mem_rd_addr_q;
    assign if_rd_ready   = if_rd_ready_q;
    assign ls_rd_ready   = ls_rd_ready_q;
    assign if_rd_data    = if_rd_data_q;
    assign ls_rd_data    = ls_rd_data_q;
    assign busy          = (state_q != IDLE);

endmodule
